// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
//   Collects up to ISSUE_WIDTH retired instructions per cycle from writeback,
//   keeps them in program order in a small FIFO and emits one registered
//   trace record per cycle on the debug_wb_* interface.
//
// Ports
//   clk, resetn          core clock, synchronous active-low reset
//   wb_valid/wen         per-lane commit valid / regfile write enable
//   wb_pc/wnum/wdata     per-lane commit fields, lane i at [W*i +: W]
//   trace_stall          pipeline must hold new commits while high
//   trace_overflow       sticky: at least one commit was dropped
//   trace_count          current FIFO occupancy
//   debug_wb_*           registered trace record (all zero when idle)
module commit_trace_serializer #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int DEPTH        = 8,
  parameter int FILTER_NOWEN = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ISSUE_WIDTH-1:0]     wb_valid,
  input  logic [32*ISSUE_WIDTH-1:0]  wb_pc,
  input  logic [ISSUE_WIDTH-1:0]     wb_wen,
  input  logic [5*ISSUE_WIDTH-1:0]   wb_wnum,
  input  logic [32*ISSUE_WIDTH-1:0]  wb_wdata,
  output logic                       trace_stall,
  output logic                       trace_overflow,
  output logic [$clog2(DEPTH+1)-1:0] trace_count,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  // Record layout: {pc[31:0], wen, wnum[4:0], wdata[31:0]}
  localparam int REC_W = 70;

  logic [REC_W-1:0]       fifo_q [DEPTH];
  logic [REC_W-1:0]       fifo_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [REC_W-1:0]       out_q, out_d;

  logic                   pop;
  logic [CNT_W-1:0]       free_slots;
  logic [CNT_W-1:0]       n_push;
  logic                   drop;
  logic [ISSUE_WIDTH-1:0] eligible;

  // Only valid lanes qualify, so data on idle lanes never reaches state.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      eligible[i] = wb_valid[i] & ((FILTER_NOWEN == 0) | wb_wen[i]);
    end
  end

  always_comb begin
    pop        = (count_q != '0);
    // The slot freed by this edge's pop is reusable by this edge's push.
    free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    fifo_d     = fifo_q;
    n_push     = '0;
    drop       = 1'b0;
    // Compact eligible lanes oldest-first; once space runs out every later
    // eligible lane is dropped, so the highest lanes go first.
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (eligible[i]) begin
        if (n_push < free_slots) begin
          fifo_d[tail_q + PTR_W'(n_push)] = {wb_pc[32*i +: 32], wb_wen[i],
                                             wb_wnum[5*i +: 5],
                                             wb_wdata[32*i +: 32]};
          n_push = n_push + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(n_push);
    count_d    = count_q + n_push - CNT_W'(pop);
    overflow_d = overflow_q | drop;
    // Pop reads the pre-edge array, so a record pushed this edge waits.
    out_d      = pop ? fifo_q[head_q] : '0;
  end

  // Control and output register stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out_q      <= out_d;
    end
  end

  // Storage stage: contents are meaningless outside [head, head+count)
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Conservative: ignores the pop that may happen at the same edge.
  assign trace_stall       = (count_q > CNT_W'(DEPTH - ISSUE_WIDTH));
  assign trace_overflow    = overflow_q;
  assign trace_count       = count_q;
  assign debug_wb_pc       = out_q[69:38];
  assign debug_wb_rf_wen   = {4{out_q[37]}};
  assign debug_wb_rf_wnum  = out_q[36:32];
  assign debug_wb_rf_wdata = out_q[31:0];

endmodule

// File: tb/tb_commit_trace_serializer.sv
module tb_commit_trace_serializer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  wb_valid;
  logic [63:0] wb_pc;
  logic [1:0]  wb_wen;
  logic [9:0]  wb_wnum;
  logic [63:0] wb_wdata;

  logic        o0_st, o0_ov, o1_st, o1_ov;
  logic [3:0]  o0_cnt, o1_cnt, o0_wen, o1_wen;
  logic [31:0] o0_pc, o1_pc, o0_wd, o1_wd;
  logic [4:0]  o0_wn, o1_wn;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  commit_trace_serializer #(.ISSUE_WIDTH(2), .DEPTH(8), .FILTER_NOWEN(0)) dut0 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_wen(wb_wen), .wb_wnum(wb_wnum), .wb_wdata(wb_wdata),
    .trace_stall(o0_st), .trace_overflow(o0_ov), .trace_count(o0_cnt),
    .debug_wb_pc(o0_pc), .debug_wb_rf_wen(o0_wen),
    .debug_wb_rf_wnum(o0_wn), .debug_wb_rf_wdata(o0_wd));

  commit_trace_serializer #(.ISSUE_WIDTH(2), .DEPTH(8), .FILTER_NOWEN(1)) dut1 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_wen(wb_wen), .wb_wnum(wb_wnum), .wb_wdata(wb_wdata),
    .trace_stall(o1_st), .trace_overflow(o1_ov), .trace_count(o1_cnt),
    .debug_wb_pc(o1_pc), .debug_wb_rf_wen(o1_wen),
    .debug_wb_rf_wnum(o1_wn), .debug_wb_rf_wdata(o1_wd));

  // Reference model: per instance, an ordered queue of traced records.
  logic [69:0] mq [2][$];
  logic        movf [2];
  logic [69:0] mout [2];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        mq[d].delete();
        movf[d] = 1'b0;
        mout[d] = '0;
      end else begin
        if (mq[d].size() > 0) mout[d] = mq[d].pop_front();
        else mout[d] = '0;
        for (int i = 0; i < 2; i++) begin
          if (wb_valid[i] && (d == 0 || wb_wen[i])) begin
            if (mq[d].size() < 8)
              mq[d].push_back({wb_pc[32*i +: 32], wb_wen[i],
                               wb_wnum[5*i +: 5], wb_wdata[32*i +: 32]});
            else
              movf[d] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [3:0] cnt, input logic st,
                         input logic ov, input logic [31:0] pc, input logic [3:0] wen,
                         input logic [4:0] wn, input logic [31:0] wd);
    string p;
    p = (d == 0) ? "dut0" : "dut1";
    chk({p, ".count"}, 70'(cnt), 70'(mq[d].size()));
    chk({p, ".stall"}, 70'(st), 70'(mq[d].size() > 6));
    chk({p, ".overflow"}, 70'(ov), 70'(movf[d]));
    chk({p, ".pc"}, 70'(pc), 70'(mout[d][69:38]));
    chk({p, ".wen"}, 70'(wen), 70'({4{mout[d][37]}}));
    chk({p, ".wnum"}, 70'(wn), 70'(mout[d][36:32]));
    chk({p, ".wdata"}, 70'(wd), 70'(mout[d][31:0]));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      cmp_dut(0, o0_cnt, o0_st, o0_ov, o0_pc, o0_wen, o0_wn, o0_wd);
      cmp_dut(1, o1_cnt, o1_st, o1_ov, o1_pc, o1_wen, o1_wn, o1_wd);
    end
  end

  task automatic go_idle();
    wb_valid = 2'b00;
    wb_wen   = 2'($urandom);
    wb_pc    = {$urandom, $urandom};
    wb_wnum  = 10'($urandom);
    wb_wdata = {$urandom, $urandom};
  endtask

  // Present one commit group for exactly one rising edge.
  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [4:0] n0, input logic [4:0] n1,
                       input logic [31:0] d0, input logic [31:0] d1);
    wb_valid = v;
    wb_wen   = w;
    wb_pc    = {pc1, pc0};
    wb_wnum  = {n1, n0};
    wb_wdata = {d1, d0};
    @(posedge clk);
    #1;
    go_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [1:0] rv;

  initial begin
    resetn = 1'b0;
    go_idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk_on = 1;

    // Reset state
    @(negedge clk);
    chk("reset.count", 70'(o0_cnt), 70'(0));
    chk("reset.wen", 70'(o0_wen), 70'(0));
    chk("reset.pc", 70'(o0_pc), 70'(0));
    chk("reset.ovf", 70'(o0_ov), 70'(0));

    // Single commit, one-cycle latency
    drive(2'b01, 2'b01, 32'hBFC00000, 32'hDEADBEEF, 5'd3, 5'd9, 32'h1234, 32'h5555);
    @(negedge clk);
    chk("single.count1", 70'(o0_cnt), 70'(1));
    chk("single.idle_first", 70'(o0_wen), 70'(0));
    @(negedge clk);
    chk("single.pc", 70'(o0_pc), 70'(32'hBFC00000));
    chk("single.wen", 70'(o0_wen), 70'(4'hF));
    chk("single.wnum", 70'(o0_wn), 70'(3));
    chk("single.wdata", 70'(o0_wd), 70'(32'h1234));
    @(negedge clk);
    chk("single.after_wen", 70'(o0_wen), 70'(0));
    chk("single.after_pc", 70'(o0_pc), 70'(0));

    // Dual commit ordering
    drive(2'b11, 2'b11, 32'h100, 32'h104, 5'd1, 5'd2, 32'hA, 32'hB);
    @(negedge clk);
    chk("dual.count_t", 70'(o0_cnt), 70'(2));
    @(negedge clk);
    chk("dual.pc0", 70'(o0_pc), 70'(32'h100));
    chk("dual.count_t1", 70'(o0_cnt), 70'(1));
    @(negedge clk);
    chk("dual.pc1", 70'(o0_pc), 70'(32'h104));
    chk("dual.count_t2", 70'(o0_cnt), 70'(0));

    // Lane1-only commit lands in the lane-0 slot position
    drive(2'b10, 2'b11, 32'hDEADBEEF, 32'h200, 5'd0, 5'd7, 32'h0, 32'h5);
    @(negedge clk);
    @(negedge clk);
    chk("lane1.pc", 70'(o0_pc), 70'(32'h200));
    chk("lane1.wnum", 70'(o0_wn), 70'(7));
    @(negedge clk);

    // Filter: lane0 wen=0 is dropped from the filtered trace only
    drive(2'b11, 2'b10, 32'h300, 32'h304, 5'd4, 5'd5, 32'h30, 32'h34);
    @(negedge clk);
    @(negedge clk);
    chk("filter.d0_pc", 70'(o0_pc), 70'(32'h300));
    chk("filter.d0_wen", 70'(o0_wen), 70'(0));
    chk("filter.d1_pc", 70'(o1_pc), 70'(32'h304));
    chk("filter.d1_wen", 70'(o1_wen), 70'(4'hF));
    @(negedge clk);
    chk("filter.d0_pc2", 70'(o0_pc), 70'(32'h304));
    chk("filter.d1_idle", 70'(o1_wen), 70'(0));
    @(negedge clk);

    // Back-to-back dual commits fill the FIFO
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 2'b11, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k),
            5'(k), 5'(k+1), 32'(k), 32'(k+100));
      @(negedge clk);
      if (k == 1) chk("b2b.first_pc", 70'(o0_pc), 70'(32'h1000));
    end
    chk("b2b.count7", 70'(o0_cnt), 70'(7));
    chk("b2b.stall", 70'(o0_st), 70'(1));
    chk("b2b.ovf0", 70'(o0_ov), 70'(0));

    // Overflow: at count 7 with a pop both lanes fit; at count 8 lane1 drops
    drive(2'b11, 2'b11, 32'h2000, 32'h2004, 5'd1, 5'd2, 32'h1, 32'h2);
    @(negedge clk);
    chk("ovf.count8", 70'(o0_cnt), 70'(8));
    chk("ovf.none_yet", 70'(o0_ov), 70'(0));
    drive(2'b11, 2'b11, 32'h3000, 32'h3004, 5'd1, 5'd2, 32'h1, 32'h2);
    @(negedge clk);
    chk("ovf.count_full", 70'(o0_cnt), 70'(8));
    chk("ovf.set", 70'(o0_ov), 70'(1));
    repeat (3) @(negedge clk);
    chk("ovf.sticky", 70'(o0_ov), 70'(1));
    chk("ovf.count5", 70'(o0_cnt), 70'(5));

    // Reset mid-drain
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst.count", 70'(o0_cnt), 70'(0));
    chk("rst.wen", 70'(o0_wen), 70'(0));
    chk("rst.ovf", 70'(o0_ov), 70'(0));
    drive(2'b01, 2'b01, 32'h4000, 32'h0, 5'd6, 5'd0, 32'h44, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.next_pc", 70'(o0_pc), 70'(32'h4000));
    chk("rst.next_wen", 70'(o0_wen), 70'(4'hF));

    // Randomized traffic, mostly honouring stall, occasional resets
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
      end else begin
        rv = 2'($urandom);
        if (o0_st && $urandom_range(0, 7) != 0) rv = 2'b00;
        drive(rv, 2'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom),
              $urandom, $urandom);
      end
    end
    go_idle();
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
